// File: rtl/tag_pkg.sv
// Shared definitions for the tag generator/verifier pair: tag width, seed,
// the per-byte accumulator step and the verifier FSM state encoding.
package tag_pkg;

  localparam int TAG_W = 8;
  localparam logic [TAG_W-1:0] TAG_INIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // One accumulator step: rotate left by one, then fold in the next byte.
  function automatic logic [TAG_W-1:0] tag_step(input logic [TAG_W-1:0] acc,
                                                input logic [7:0]       byte_v);
    return {acc[TAG_W-2:0], acc[TAG_W-1]} ^ byte_v;
  endfunction

endpackage

// File: rtl/tag_calc_serial.sv
// Byte-serial tag accumulator. start seeds the accumulator, each step folds in
// byte_i, and done pulses for one cycle after the step flagged as last.
module tag_calc_serial
  import tag_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [7:0]       byte_i,
  input  logic             last_i,
  output logic [TAG_W-1:0] acc_o,
  output logic             done_o
);

  logic [TAG_W-1:0] acc_q;
  logic             done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= TAG_INIT;
      done_q <= 1'b0;
    end else begin
      done_q <= step_i & last_i;
      if (start_i) begin
        acc_q <= TAG_INIT;
      end else if (step_i) begin
        acc_q <= tag_step(acc_q, byte_i);
      end
    end
  end

  assign acc_o  = acc_q;
  assign done_o = done_q;

endmodule

// File: rtl/tag_verifier.sv
// Receiver-side tag checker: latches a data word and its tag, recomputes the
// tag one byte per cycle, and returns match/calc_tag over a valid/ready port.
module tag_verifier #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = tag_pkg::TAG_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              match,
  output logic [TAG_W-1:0]  calc_tag,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              sticky_err,
  input  logic              clear_counts
);

  import tag_pkg::*;

  localparam int NUM_BYTES = DATA_W / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_e              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                match_q;
  logic [TAG_W-1:0]    calc_tag_q;
  logic [TAG_W-1:0]    tag_q;
  logic [DATA_W-1:0]   data_q;
  logic [IDX_W-1:0]    byte_idx_q;

  logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic                sticky_q,   sticky_d;

  logic                accept;
  logic                step;
  logic                last_byte;
  logic                load_result;
  logic                tag_ok;
  logic [TAG_W-1:0]    calc_acc;
  logic                calc_done;

  assign accept      = (state_q == IDLE) && in_valid;
  assign step        = (state_q == CALC) && !calc_done;
  assign last_byte   = (byte_idx_q == IDX_W'(NUM_BYTES - 1));
  assign load_result = (state_q == CALC) && calc_done;
  assign tag_ok      = (calc_acc == tag_q);

  // The latched word is shifted left each step so the MSB byte is always on top.
  tag_calc_serial u_calc (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (accept),
    .step_i  (step),
    .byte_i  (data_q[DATA_W-1 -: 8]),
    .last_i  (last_byte),
    .acc_o   (calc_acc),
    .done_o  (calc_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      match_q     <= 1'b0;
      calc_tag_q  <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      byte_idx_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= data;
            tag_q      <= tag_in;
            byte_idx_q <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (calc_done) begin
            calc_tag_q  <= calc_acc;
            match_q     <= tag_ok;
            out_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            data_q     <= data_q << 8;
            byte_idx_q <= byte_idx_q + 1'b1;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every signal assigned here gets a default first, so no latch is
  // inferred on paths that leave it untouched.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    sticky_d   = sticky_q;
    if (clear_counts) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      sticky_d   = 1'b0;
    end else if (load_result) begin
      if (tag_ok) begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
      end else begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign match      = match_q;
  assign calc_tag   = calc_tag_q;
  assign pass_count = pass_cnt_q;
  assign fail_count = fail_cnt_q;
  assign sticky_err = sticky_q;

endmodule

// File: tb/tb_tag_verifier.sv
// Directed bench for tag_verifier: a default-width instance plus a CNT_W=2
// instance on the same stimulus for counter saturation.
module tb_tag_verifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] data;
  logic [7:0]  tag_in;
  logic        out_ready;
  logic        clear_counts;

  logic        m_in_ready, m_out_valid, m_match, m_sticky;
  logic [7:0]  m_calc_tag;
  logic [15:0] m_pass, m_fail;

  logic        s_in_ready, s_out_valid, s_match, s_sticky;
  logic [7:0]  s_calc_tag;
  logic [1:0]  s_pass, s_fail;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tag_verifier dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
    .data(data), .tag_in(tag_in), .out_valid(m_out_valid), .out_ready(out_ready),
    .match(m_match), .calc_tag(m_calc_tag), .pass_count(m_pass), .fail_count(m_fail),
    .sticky_err(m_sticky), .clear_counts(clear_counts)
  );

  tag_verifier #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .data(data), .tag_in(tag_in), .out_valid(s_out_valid), .out_ready(out_ready),
    .match(s_match), .calc_tag(s_calc_tag), .pass_count(s_pass), .fail_count(s_fail),
    .sticky_err(s_sticky), .clear_counts(clear_counts)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for the accept edge, then scramble the inputs.
  task automatic start_txn(input logic [31:0] d, input logic [7:0] t);
    in_valid = 1'b1;
    data     = d;
    tag_in   = t;
    tick();
    in_valid = 1'b0;
    data     = 32'hDEAD_BEEF;
    tag_in   = 8'hA5;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (m_out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0; data = '0; tag_in = '0; out_ready = 1'b0; clear_counts = 1'b0;
    repeat (2) tick();
    n_cmp++; if (m_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", m_in_ready); end
    n_cmp++; if (m_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", m_out_valid); end
    n_cmp++; if (m_pass !== 16'd0 || m_fail !== 16'd0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d want 0/0", m_pass, m_fail); end
    n_cmp++; if (m_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_sticky got %b want 0", m_sticky); end
    n_cmp++; if (m_match !== 1'b0 || m_calc_tag !== 8'h00) begin n_bad++; $display("FAIL reset_result got %b/%h want 0/00", m_match, m_calc_tag); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_match();
    int lat;
    out_ready = 1'b1;
    start_txn(32'h1234_5678, 8'h94);
    n_cmp++; if (m_in_ready !== 1'b0) begin n_bad++; $display("FAIL match_busy got in_ready=%b want 0", m_in_ready); end
    wait_result(lat);
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL match_latency got %0d want 5", lat); end
    n_cmp++; if (m_calc_tag !== 8'h94) begin n_bad++; $display("FAIL match_calc_tag got %h want 94", m_calc_tag); end
    n_cmp++; if (m_match !== 1'b1) begin n_bad++; $display("FAIL match_flag got %b want 1", m_match); end
    n_cmp++; if (m_pass !== 16'd1 || m_fail !== 16'd0) begin n_bad++; $display("FAIL match_counts got %0d/%0d want 1/0", m_pass, m_fail); end
    n_cmp++; if (m_sticky !== 1'b0) begin n_bad++; $display("FAIL match_sticky got %b want 0", m_sticky); end
    tick();
    n_cmp++; if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin n_bad++; $display("FAIL match_handshake got ov=%b ir=%b want 0/1", m_out_valid, m_in_ready); end
    n_cmp++; if (m_calc_tag !== 8'h94 || m_match !== 1'b1) begin n_bad++; $display("FAIL match_hold got %h/%b want 94/1", m_calc_tag, m_match); end
  endtask

  task automatic test_mismatch();
    int lat;
    out_ready = 1'b1;
    start_txn(32'h8765_4321, 8'h1F);
    wait_result(lat);
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL mismatch_latency got %0d want 5", lat); end
    n_cmp++; if (m_calc_tag !== 8'h0E) begin n_bad++; $display("FAIL mismatch_calc_tag got %h want 0e", m_calc_tag); end
    n_cmp++; if (m_match !== 1'b0) begin n_bad++; $display("FAIL mismatch_flag got %b want 0", m_match); end
    n_cmp++; if (m_pass !== 16'd1 || m_fail !== 16'd1) begin n_bad++; $display("FAIL mismatch_counts got %0d/%0d want 1/1", m_pass, m_fail); end
    n_cmp++; if (m_sticky !== 1'b1) begin n_bad++; $display("FAIL mismatch_sticky got %b want 1", m_sticky); end
    tick();
    n_cmp++; if (m_sticky !== 1'b1) begin n_bad++; $display("FAIL mismatch_sticky_hold got %b want 1", m_sticky); end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad_hold = 0;
    logic seen = 1'b0;
    out_ready = 1'b0;
    start_txn(32'hFFFF_FFFF, 8'h00);
    wait_result(lat);
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL bp_latency got %0d want 5", lat); end
    for (int i = 0; i < 4; i++) begin
      if (m_out_valid !== 1'b1 || m_match !== 1'b1 || m_calc_tag !== 8'h00 || m_in_ready !== 1'b0)
        bad_hold++;
      in_valid = (i == 1);
      data     = 32'h1234_5678;
      tag_in   = 8'h94;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (bad_hold != 0) begin n_bad++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad_hold); end
    n_cmp++; if (m_out_valid !== 1'b1 || m_calc_tag !== 8'h00) begin n_bad++; $display("FAIL bp_still_valid got %b/%h want 1/00", m_out_valid, m_calc_tag); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (m_out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got %b want 0", m_out_valid); end
    repeat (8) begin
      if (m_out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL bp_ignored_req got extra out_valid=%b want 0", seen); end
    n_cmp++; if (m_pass !== 16'd2 || m_fail !== 16'd1) begin n_bad++; $display("FAIL bp_counts got %0d/%0d want 2/1", m_pass, m_fail); end
  endtask

  task automatic test_saturate_clear();
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_txn(32'h8765_4321, 8'h00);
      wait_result(lat);
      tick();
    end
    n_cmp++; if (s_fail !== 2'd3) begin n_bad++; $display("FAIL sat_small_fail got %0d want 3", s_fail); end
    n_cmp++; if (m_fail !== 16'd6) begin n_bad++; $display("FAIL sat_main_fail got %0d want 6", m_fail); end
    n_cmp++; if (s_pass !== 2'd2 || s_sticky !== 1'b1) begin n_bad++; $display("FAIL sat_small_other got %0d/%b want 2/1", s_pass, s_sticky); end
    start_txn(32'h8765_4321, 8'h00);
    repeat (4) tick();
    n_cmp++; if (m_out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_early_valid got %b want 0", m_out_valid); end
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    n_cmp++; if (m_out_valid !== 1'b1 || m_match !== 1'b0) begin n_bad++; $display("FAIL clr_result got %b/%b want 1/0", m_out_valid, m_match); end
    n_cmp++; if (m_fail !== 16'd0 || s_fail !== 2'd0) begin n_bad++; $display("FAIL clr_fail got %0d/%0d want 0/0", m_fail, s_fail); end
    n_cmp++; if (m_pass !== 16'd0 || m_sticky !== 1'b0 || s_sticky !== 1'b0) begin n_bad++; $display("FAIL clr_rest got %0d/%b/%b want 0/0/0", m_pass, m_sticky, s_sticky); end
    tick();
  endtask

  task automatic test_reset_mid_calc();
    logic seen = 1'b0;
    out_ready = 1'b1;
    start_txn(32'h1234_5678, 8'h94);
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_async got ir=%b ov=%b want 1/0", m_in_ready, m_out_valid); end
    tick();
    reset = 1'b1;
    repeat (8) begin
      if (m_out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_result got out_valid=%b want 0", seen); end
    n_cmp++; if (m_pass !== 16'd0 || m_fail !== 16'd0) begin n_bad++; $display("FAIL midrst_counts got %0d/%0d want 0/0", m_pass, m_fail); end
    n_cmp++; if (m_in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", m_in_ready); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_backpressure();
    test_saturate_clear();
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
